instr_mem_loader: RTL and testbench

- Receives a program as a byte stream from the debug UART receiver.
- Packs each group of four bytes into a 32-bit instruction word and writes it sequentially into instruction memory, starting at word address 0.
- Stops after it writes the halt word, or when instruction memory is full.
- Sits between the UART receiver and the instruction-memory write port. It is the producer of the words that fetch reads and the control unit decodes.

---
 rtl/instr_mem_loader_pkg.sv | 20 ++
 rtl/instr_mem_loader_packer.sv | 45 ++++
 rtl/instr_mem_loader.sv | 143 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the program loader and the debug unit.
// Both blocks recognise the same end-of-program marker, so it lives here.
package instr_mem_loader_pkg;

    // Number of UART bytes that make up one instruction word.
    localparam int BYTES_PER_WORD = 4;

    // End-of-program marker. The loader stops after writing it and the
    // debug unit treats it as a halt instruction.
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    // Loader session states, fixed to a 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } loader_state_t;

endpackage

// File: rtl/instr_mem_loader_packer.sv
// Packs UART bytes into big-endian instruction words.
// The first byte of each group lands in the top byte of the word, so the
// opcode byte is the first one on the wire. word_ready marks the capture
// that completes a word. o_word is the assembled word including the byte
// being captured, so the caller can latch it on that same edge.
module byte_to_word_packer
    import instr_mem_loader_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_capture,
    input  logic [NB_BYTE-1:0] i_byte,
    output logic [NB_DATA-1:0] o_word,
    output logic               o_word_ready
);

    localparam int NB_COUNT = $clog2(BYTES_PER_WORD);
    localparam logic [NB_COUNT-1:0] LAST_BYTE = NB_COUNT'(BYTES_PER_WORD - 1);

    logic [NB_DATA-1:0]  shift_reg;
    logic [NB_COUNT-1:0] byte_count;

    assign o_word       = {shift_reg[NB_DATA-NB_BYTE-1:0], i_byte};
    assign o_word_ready = i_capture && (byte_count == LAST_BYTE);

    // Shift each captured byte in from the bottom and count modulo four;
    // a session start wipes any partial word.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            shift_reg  <= '0;
            byte_count <= '0;
        end else if (i_clear) begin
            shift_reg  <= '0;
            byte_count <= '0;
        end else if (i_capture) begin
            shift_reg  <= o_word;
            byte_count <= o_word_ready ? '0 : byte_count + 1'b1;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Program loader between the debug UART receiver and the instruction
// memory write port. A session opened by i_start packs incoming bytes into
// words and writes them at consecutive addresses from 0 until the halt
// word has been written or the last address has been used.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_BYTE   = 8,
    parameter int                 NB_ADDR   = 10,
    parameter logic [NB_DATA-1:0] HALT_WORD = NB_DATA'(HALT_WORD_DEFAULT)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_mem_wr_enb,
    output logic [NB_ADDR-1:0] o_mem_wr_addr,
    output logic [NB_DATA-1:0] o_mem_wr_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overflow,
    output logic [NB_ADDR:0]   o_word_count
);

    loader_state_t      state;
    loader_state_t      next_state;
    logic               start_accept;
    logic               capture;
    logic               word_ready;
    logic [NB_DATA-1:0] packed_word;
    logic               halt_hit;
    logic               last_addr;

    // o_mem_wr_data holds the word being written while in WRITE, and
    // o_mem_wr_addr is the address register itself.
    assign halt_hit  = (o_mem_wr_data == HALT_WORD);
    assign last_addr = &o_mem_wr_addr;

    assign start_accept = i_start && ((state == ST_IDLE) || (state == ST_DONE));

    // Bytes are taken while receiving, and also during a WRITE that goes
    // back to RECEIVE, where the byte starts the next word. A byte arriving
    // in a WRITE that ends the session is dropped.
    assign capture = i_rx_valid &&
                     ((state == ST_RECEIVE) ||
                      ((state == ST_WRITE) && !halt_hit && !last_addr));

    byte_to_word_packer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_packer (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_clear      (start_accept),
        .i_capture    (capture),
        .i_byte       (i_rx_data),
        .o_word       (packed_word),
        .o_word_ready (word_ready)
    );

    // State register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: WRITE always lasts one cycle and decides between
    // ending the session and collecting another word.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    next_state = ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                if (word_ready) begin
                    next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (halt_hit || last_addr) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_RECEIVE;
                end
            end
            ST_DONE: begin
                if (i_start) begin
                    next_state = ST_RECEIVE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, address counter and session flags. Status
    // outputs follow the state being entered, so they are valid in the
    // same cycle as that state.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_mem_wr_enb  <= 1'b0;
            o_mem_wr_addr <= '0;
            o_mem_wr_data <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_overflow    <= 1'b0;
            o_word_count  <= '0;
        end else begin
            o_mem_wr_enb <= (next_state == ST_WRITE);
            o_busy       <= (next_state == ST_RECEIVE) || (next_state == ST_WRITE);
            o_done       <= (next_state == ST_DONE);

            if (start_accept) begin
                o_mem_wr_addr <= '0;
                o_word_count  <= '0;
                o_overflow    <= 1'b0;
            end else if (state == ST_WRITE) begin
                o_word_count <= o_word_count + 1'b1;
                if (!halt_hit) begin
                    if (last_addr) begin
                        o_overflow <= 1'b1;
                    end else begin
                        o_mem_wr_addr <= o_mem_wr_addr + 1'b1;
                    end
                end
            end

            if ((state == ST_RECEIVE) && word_ready) begin
                o_mem_wr_data <= packed_word;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader. A full-size loader and a 4-word loader share
// the byte stream and reset; each only reacts while its own session runs.
// Expected writes come from grouping the byte stream into big-endian words
// and cutting the list at the halt word or at the memory size.
module tb_instr_mem_loader;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start_big = 1'b0;
    logic        start_small = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        sel = 1'b0;

    logic        b_enb, b_busy, b_done, b_ovf;
    logic [9:0]  b_addr;
    logic [31:0] b_data;
    logic [10:0] b_count;

    logic        s_enb, s_busy, s_done, s_ovf;
    logic [1:0]  s_addr;
    logic [31:0] s_data;
    logic [2:0]  s_count;

    logic        obs_enb, obs_busy, obs_done, obs_ovf;
    logic [9:0]  obs_addr;
    logic [31:0] obs_data;
    logic [10:0] obs_count;

    logic [31:0] words[$];
    int          n_compared = 0;
    int          n_mismatched = 0;

    instr_mem_loader dut (
        .i_clock       (clock),
        .i_reset       (reset_n),
        .i_start       (start_big),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .o_mem_wr_enb  (b_enb),
        .o_mem_wr_addr (b_addr),
        .o_mem_wr_data (b_data),
        .o_busy        (b_busy),
        .o_done        (b_done),
        .o_overflow    (b_ovf),
        .o_word_count  (b_count)
    );

    instr_mem_loader #(.NB_ADDR(2)) dut_small (
        .i_clock       (clock),
        .i_reset       (reset_n),
        .i_start       (start_small),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .o_mem_wr_enb  (s_enb),
        .o_mem_wr_addr (s_addr),
        .o_mem_wr_data (s_data),
        .o_busy        (s_busy),
        .o_done        (s_done),
        .o_overflow    (s_ovf),
        .o_word_count  (s_count)
    );

    assign obs_enb   = sel ? s_enb : b_enb;
    assign obs_busy  = sel ? s_busy : b_busy;
    assign obs_done  = sel ? s_done : b_done;
    assign obs_ovf   = sel ? s_ovf : b_ovf;
    assign obs_addr  = sel ? {8'b0, s_addr} : b_addr;
    assign obs_data  = sel ? s_data : b_data;
    assign obs_count = sel ? {8'b0, s_count} : b_count;

    always #5 clock = ~clock;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
        return w[(31 - 8 * i) -: 8];
    endfunction

    // One clock cycle: inputs applied half a cycle before the rising edge,
    // outputs observed at the following falling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic s);
        rx_valid    = v;
        rx_data     = d;
        start_big   = s && !sel;
        start_small = s && sel;
        @(posedge clock);
        @(negedge clock);
        rx_valid    = 1'b0;
        start_big   = 1'b0;
        start_small = 1'b0;
    endtask

    task automatic make_words(input int n, input logic end_with_halt);
        logic [31:0] w;
        words.delete();
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            if (w == HALT) w = 32'h0;
            words.push_back(w);
        end
        if (end_with_halt) words.push_back(HALT);
    endtask

    // Runs a complete session over the words queue and checks every cycle.
    task automatic run_session(input int limit, input int max_gap,
                               input logic start_with_byte, input string name);
        int          exp_n;
        logic        exp_ovf;
        int          gap;
        logic [31:0] w;
        exp_n = 0;
        while (exp_n < words.size()) begin
            exp_n++;
            if (words[exp_n-1] == HALT) break;
            if (exp_n == limit) break;
        end
        exp_ovf = (exp_n == limit) && (words[exp_n-1] != HALT);

        step(start_with_byte, 8'($urandom), 1'b1);
        n_compared++;
        if (obs_busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL %s start busy: got %b expected 1", name, obs_busy); end
        n_compared++;
        if (obs_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL %s start done: got %b expected 0", name, obs_done); end
        n_compared++;
        if (obs_count !== 11'd0 || obs_ovf !== 1'b0) begin n_mismatched++; $display("[TB] FAIL %s start clears: got count %0d ovf %b expected 0 0", name, obs_count, obs_ovf); end

        for (int i = 0; i < exp_n * 4; i++) begin
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 8'h00, 1'b0);
                n_compared++;
                if (obs_enb !== 1'b0) begin n_mismatched++; $display("[TB] FAIL %s idle-cycle enb: got %b expected 0", name, obs_enb); end
            end
            w = words[i/4];
            step(1'b1, byte_of(w, i % 4), 1'b0);
            if (i % 4 == 3) begin
                n_compared++;
                if (obs_enb !== 1'b1) begin n_mismatched++; $display("[TB] FAIL %s write %0d enb: got %b expected 1", name, i/4, obs_enb); end
                n_compared++;
                if (obs_addr !== 10'(i/4)) begin n_mismatched++; $display("[TB] FAIL %s write %0d addr: got %0d expected %0d", name, i/4, obs_addr, i/4); end
                n_compared++;
                if (obs_data !== w) begin n_mismatched++; $display("[TB] FAIL %s write %0d data: got %h expected %h", name, i/4, obs_data, w); end
            end else begin
                n_compared++;
                if (obs_enb !== 1'b0) begin n_mismatched++; $display("[TB] FAIL %s byte %0d enb: got %b expected 0", name, i, obs_enb); end
            end
        end

        step(1'b1, 8'($urandom), 1'b0);
        n_compared++;
        if (obs_done !== 1'b1 || obs_busy !== 1'b0 || obs_enb !== 1'b0) begin n_mismatched++; $display("[TB] FAIL %s end flags: got done %b busy %b enb %b expected 1 0 0", name, obs_done, obs_busy, obs_enb); end
        n_compared++;
        if (obs_count !== 11'(exp_n)) begin n_mismatched++; $display("[TB] FAIL %s word count: got %0d expected %0d", name, obs_count, exp_n); end
        n_compared++;
        if (obs_ovf !== exp_ovf) begin n_mismatched++; $display("[TB] FAIL %s overflow: got %b expected %b", name, obs_ovf, exp_ovf); end

        for (int k = 0; k < 5; k++) begin
            step(1'b1, 8'($urandom), 1'b0);
            n_compared++;
            if (obs_enb !== 1'b0 || obs_done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL %s after done: got enb %b done %b expected 0 1", name, obs_enb, obs_done); end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        n_compared++;
        if ({b_enb, b_busy, b_done, b_ovf} !== 4'b0) begin n_mismatched++; $display("[TB] FAIL reset flags: got %b expected 0000", {b_enb, b_busy, b_done, b_ovf}); end
        n_compared++;
        if (b_addr !== 10'd0 || b_data !== 32'd0 || b_count !== 11'd0) begin n_mismatched++; $display("[TB] FAIL reset values: got addr %0d data %h count %0d expected 0", b_addr, b_data, b_count); end
        n_compared++;
        if ({s_enb, s_busy, s_done, s_ovf} !== 4'b0) begin n_mismatched++; $display("[TB] FAIL reset small flags: got %b expected 0000", {s_enb, s_busy, s_done, s_ovf}); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_ignored_idle;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 8'($urandom), 1'b0);
            n_compared++;
            if (obs_enb !== 1'b0 || obs_busy !== 1'b0 || obs_count !== 11'd0) begin n_mismatched++; $display("[TB] FAIL idle rx: got enb %b busy %b count %0d expected 0 0 0", obs_enb, obs_busy, obs_count); end
        end
    endtask

    task automatic test_normal_load;
        words.delete();
        words.push_back(32'h2001_0005);
        words.push_back(32'h2002_0007);
        words.push_back(HALT);
        run_session(1024, 1, 1'b0, "normal");
    endtask

    task automatic test_restart_from_done;
        make_words(2, 1'b1);
        run_session(1024, 2, 1'b1, "restart");
    endtask

    task automatic test_back_to_back;
        make_words(4, 1'b1);
        run_session(1024, 0, 1'b0, "back_to_back");
    endtask

    task automatic test_start_during_receive;
        logic [31:0] w;
        make_words(2, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 12; i++) begin
            w = words[i/4];
            step(1'b1, byte_of(w, i % 4), 1'b0);
            if (i == 5) begin
                step(1'b0, 8'h00, 1'b1);
                n_compared++;
                if (obs_busy !== 1'b1 || obs_count !== 11'd1 || obs_enb !== 1'b0) begin n_mismatched++; $display("[TB] FAIL start_in_receive: got busy %b count %0d enb %b expected 1 1 0", obs_busy, obs_count, obs_enb); end
            end
            if (i % 4 == 3) begin
                n_compared++;
                if (obs_enb !== 1'b1 || obs_addr !== 10'(i/4) || obs_data !== w) begin n_mismatched++; $display("[TB] FAIL start_in_receive write %0d: got enb %b addr %0d data %h expected 1 %0d %h", i/4, obs_enb, obs_addr, obs_data, i/4, w); end
            end
        end
        step(1'b0, 8'h00, 1'b0);
        n_compared++;
        if (obs_done !== 1'b1 || obs_count !== 11'd3) begin n_mismatched++; $display("[TB] FAIL start_in_receive end: got done %b count %0d expected 1 3", obs_done, obs_count); end
    endtask

    task automatic test_reset_mid_session;
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        reset_n = 1'b0;
        #1;
        n_compared++;
        if (b_busy !== 1'b0 || b_count !== 11'd0 || b_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL async reset partial: got busy %b count %0d done %b expected 0 0 0", b_busy, b_count, b_done); end
        @(negedge clock);
        reset_n = 1'b1;

        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
        n_compared++;
        if (b_enb !== 1'b1) begin n_mismatched++; $display("[TB] FAIL pre-reset write enb: got %b expected 1", b_enb); end
        reset_n = 1'b0;
        #1;
        n_compared++;
        if (b_enb !== 1'b0 || b_data !== 32'd0 || b_addr !== 10'd0) begin n_mismatched++; $display("[TB] FAIL async reset write: got enb %b data %h addr %0d expected 0 0 0", b_enb, b_data, b_addr); end
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 8'h33, 1'b0);
        n_compared++;
        if (b_busy !== 1'b0 || b_enb !== 1'b0) begin n_mismatched++; $display("[TB] FAIL after reset idle: got busy %b enb %b expected 0 0", b_busy, b_enb); end

        make_words(1, 1'b1);
        run_session(1024, 1, 1'b0, "post_reset");
    endtask

    task automatic test_overflow;
        sel = 1'b1;
        make_words(4, 1'b0);
        run_session(4, 1, 1'b0, "overflow");
        make_words(3, 1'b1);
        run_session(4, 1, 1'b1, "halt_at_last_addr");
        make_words(1, 1'b1);
        run_session(4, 0, 1'b0, "small_short");
        sel = 1'b0;
    endtask

    task automatic test_random;
        for (int s = 0; s < 10; s++) begin
            make_words($urandom_range(0, 7), 1'b1);
            run_session(1024, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_ignored_idle();
        test_normal_load();
        test_restart_from_done();
        test_back_to_back();
        test_start_during_receive();
        test_reset_mid_session();
        test_overflow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
